// File: rtl/instr_enc_pkg.sv
// instr_enc_pkg
//   Shared definitions for the instruction encoder: opcode constants,
//   the in_kind encoding, the FSM state type and the word encoder.
package instr_enc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_LW    = 6'b100011;

    typedef enum logic [1:0] {
        KIND_R   = 2'b00,
        KIND_BEQ = 2'b01,
        KIND_SW  = 2'b10,
        KIND_LW  = 2'b11
    } kind_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // R-type ignores imm; I-types ignore rd and funct.
    function automatic logic [31:0] encode(
        input logic [1:0]  kind,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [5:0]  funct,
        input logic [15:0] imm
    );
        logic [31:0] w;
        case (kind)
            KIND_BEQ: w = {OP_BEQ, rs, rt, imm};
            KIND_SW:  w = {OP_SW,  rs, rt, imm};
            KIND_LW:  w = {OP_LW,  rs, rt, imm};
            default:  w = {OP_RTYPE, rs, rt, rd, 5'b00000, funct};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// instr_encoder_if
//   Request side and memory-write side of the instruction encoder.
//   Handshake: a request transfers on a cycle where in_valid=1 and
//   in_ready=1; in_ready depends only on registered state. A memory
//   write completes on a cycle where mem_we=1 and mem_ack=1; mem_ack
//   with mem_we=0 has no effect.
//   slave  : the encoder block
//   master : the request source / memory model
interface instr_encoder_if #(parameter int AW = 8);
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_kind;
    logic [4:0]    in_rs;
    logic [4:0]    in_rt;
    logic [4:0]    in_rd;
    logic [5:0]    in_funct;
    logic [15:0]   in_imm;
    logic          base_load;
    logic [AW-1:0] base_addr;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_ack;
    logic [AW:0]   words_written;
    logic          full_err;

    modport slave (
        input  in_valid, in_kind, in_rs, in_rt, in_rd, in_funct, in_imm,
        input  base_load, base_addr, mem_ack,
        output in_ready, mem_we, mem_addr, mem_wdata, words_written, full_err
    );

    modport master (
        output in_valid, in_kind, in_rs, in_rt, in_rd, in_funct, in_imm,
        output base_load, base_addr, mem_ack,
        input  in_ready, mem_we, mem_addr, mem_wdata, words_written, full_err
    );
endinterface

// File: rtl/enc_fifo.sv
// enc_fifo
//   DEPTH x W synchronous FIFO with count-based full/empty.
//   Ports: clk, rst_n (async active-low), push/din, pop/dout (head,
//   valid when !empty), count, full, empty.
module enc_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            if (do_push && !do_pop)      cnt <= cnt + (PW+1)'(1);
            else if (do_pop && !do_push) cnt <= cnt - (PW+1)'(1);
        end
    end

    assign dout  = mem[rd_ptr];
    assign count = cnt;
    assign full  = (cnt == (PW+1)'(DEPTH));
    assign empty = (cnt == '0);
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder
//   Encodes MIPS-style instruction requests into 32-bit words, buffers
//   them in enc_fifo and writes them to sequential instruction-memory
//   addresses. Stops in FULL (full_err) instead of wrapping the address.
//   Ports: clk, rst_n (async active-low), bus (instr_encoder_if.slave),
//   dbg_state (current FSM state).
module instr_encoder
    import instr_enc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    instr_encoder_if.slave  bus,
    output state_t          dbg_state
);
    localparam int CW = $clog2(DEPTH) + 1;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW:0]   ww_q, ww_d;
    logic          ferr_q, ferr_d;

    logic          push, pop;
    logic [31:0]   head;
    logic [CW-1:0] count;
    logic          fifo_full, fifo_empty;

    assign bus.in_ready = !fifo_full && (state_q != ST_FULL);
    assign push = bus.in_valid && bus.in_ready;

    enc_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (encode(bus.in_kind, bus.in_rs, bus.in_rt, bus.in_rd,
                       bus.in_funct, bus.in_imm)),
        .pop   (pop),
        .dout  (head),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        ww_d    = ww_q;
        ferr_d  = ferr_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.base_load) begin
                    addr_d = bus.base_addr;
                    ww_d   = '0;
                    ferr_d = 1'b0;
                end
                // Looking at push too gives the N+1 first-write latency.
                if (!fifo_empty || push) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (bus.mem_ack) begin
                    pop  = 1'b1;
                    ww_d = ww_q + (AW+1)'(1);
                    if (addr_q == '1) begin
                        // Last address used: park without wrapping.
                        state_d = ST_FULL;
                        ferr_d  = 1'b1;
                    end else begin
                        addr_d = addr_q + AW'(1);
                        if (count == CW'(1) && !push) state_d = ST_IDLE;
                    end
                end
            end
            ST_FULL: begin
                if (bus.base_load) begin
                    addr_d  = bus.base_addr;
                    ww_d    = '0;
                    ferr_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            ww_q    <= '0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            ww_q    <= ww_d;
            ferr_q  <= ferr_d;
        end
    end

    assign bus.mem_we        = (state_q == ST_WRITE);
    assign bus.mem_wdata     = (state_q == ST_WRITE) ? head : 32'h0;
    assign bus.mem_addr      = addr_q;
    assign bus.words_written = ww_q;
    assign bus.full_err      = ferr_q;
    assign dbg_state         = state_q;
endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;
  import instr_enc_pkg::*;

  localparam int AW = 8;

  logic   clk;
  logic   rst_n;
  state_t dbg_state;

  int checks = 0;
  int errors = 0;

  // Expected completed writes: {addr, data}
  logic [AW+31:0] exp_q[$];

  instr_encoder_if #(.AW(AW)) bus ();

  instr_encoder #(.DEPTH(4), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: every write that completes must be the next expected one.
  always @(negedge clk) begin
    if (rst_n && bus.mem_we && bus.mem_ack) begin
      check("wr_pending", 40'(exp_q.size() != 0), 40'd1);
      if (exp_q.size() != 0) check("wr_addr_data", {bus.mem_addr, bus.mem_wdata}, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_base(input logic [AW-1:0] a);
    bus.base_addr = a;
    bus.base_load = 1'b1;
    tick();
    bus.base_load = 1'b0;
  endtask

  // Offers one request until accepted (bounded); returns just after the transfer edge.
  task automatic send(input logic [1:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [5:0] funct, input logic [15:0] imm);
    logic ok;
    int   n;
    bus.in_kind  = kind;
    bus.in_rs    = rs;
    bus.in_rt    = rt;
    bus.in_rd    = rd;
    bus.in_funct = funct;
    bus.in_imm   = imm;
    bus.in_valid = 1'b1;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = bus.in_ready;
      tick();
      n++;
    end
    bus.in_valid = 1'b0;
    if (!ok) check("send_timeout", 40'd0, 40'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int accepted;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_kind   = 2'b00;
    bus.in_rs     = '0;
    bus.in_rt     = '0;
    bus.in_rd     = '0;
    bus.in_funct  = '0;
    bus.in_imm    = '0;
    bus.base_load = 1'b0;
    bus.base_addr = '0;
    bus.mem_ack   = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_mem_we", 40'(bus.mem_we), 40'd0);
    check("rst_mem_addr", 40'(bus.mem_addr), 40'd0);
    check("rst_mem_wdata", 40'(bus.mem_wdata), 40'd0);
    check("rst_words", 40'(bus.words_written), 40'd0);
    check("rst_full_err", 40'(bus.full_err), 40'd0);
    check("rst_state", 40'(dbg_state), 40'(ST_IDLE));
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    @(negedge clk);
    check("rst_in_ready", 40'(bus.in_ready), 40'd1);
    tick();

    // lw rs=2 rt=3 imm=4: write visible the cycle after acceptance
    send(KIND_LW, 5'd2, 5'd3, 5'd0, 6'd0, 16'h0004);
    @(negedge clk);
    check("lw_we", 40'(bus.mem_we), 40'd1);
    check("lw_addr", 40'(bus.mem_addr), 40'h00);
    check("lw_wdata", 40'(bus.mem_wdata), 40'h8C430004);
    exp_q.push_back({8'h00, 32'h8C430004});
    tick();
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    tick();
    @(negedge clk);
    check("lw_words", 40'(bus.words_written), 40'd1);
    check("lw_idle", 40'(dbg_state), 40'(ST_IDLE));
    check("lw_addr_inc", 40'(bus.mem_addr), 40'h01);
    tick();

    // sw / beq / R back-to-back with ack tied high
    load_base(8'h00);
    bus.mem_ack = 1'b1;
    exp_q.push_back({8'h00, 32'hAC430008});
    exp_q.push_back({8'h01, 32'h1022FFFF});
    exp_q.push_back({8'h02, 32'h00221820});
    send(KIND_SW, 5'd2, 5'd3, 5'd31, 6'h3F, 16'h0008);
    send(KIND_BEQ, 5'd1, 5'd2, 5'd31, 6'h3F, 16'hFFFF);
    send(KIND_R, 5'd1, 5'd2, 5'd3, 6'h20, 16'hABCD);
    @(negedge clk);
    check("b2b_third_we", 40'(bus.mem_we), 40'd1);
    check("b2b_third_addr", 40'(bus.mem_addr), 40'h02);
    check("b2b_words_mid", 40'(bus.words_written), 40'd2);
    repeat (3) tick();
    @(negedge clk);
    check("b2b_words", 40'(bus.words_written), 40'd3);
    check("b2b_idle", 40'(dbg_state), 40'(ST_IDLE));
    bus.mem_ack = 1'b0;
    tick();

    // Backpressure: six offers with ack low, only four fit
    load_base(8'h40);
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      bus.in_kind  = KIND_LW;
      bus.in_rs    = 5'd1;
      bus.in_rt    = 5'd1;
      bus.in_imm   = 16'h0100 + 16'(i);
      bus.in_valid = 1'b1;
      @(negedge clk);
      if (bus.in_ready) accepted++;
      tick();
    end
    bus.in_valid = 1'b0;
    check("bp_accepted", 40'(accepted), 40'd4);
    @(negedge clk);
    check("bp_in_ready", 40'(bus.in_ready), 40'd0);
    check("bp_wdata_a", 40'(bus.mem_wdata), 40'h8C210100);
    repeat (2) tick();
    @(negedge clk);
    check("bp_wdata_b", 40'(bus.mem_wdata), 40'h8C210100);
    check("bp_addr", 40'(bus.mem_addr), 40'h40);
    for (int i = 0; i < 4; i++) exp_q.push_back({8'h40 + 8'(i), 32'h8C210100 + 32'(i)});
    tick();
    bus.mem_ack = 1'b1;
    repeat (6) tick();
    @(negedge clk);
    check("bp_words", 40'(bus.words_written), 40'd4);
    check("bp_ready_again", 40'(bus.in_ready), 40'd1);
    bus.mem_ack = 1'b0;
    tick();

    // Address exhaustion at 0xFF, then reload at 0x10
    load_base(8'hFE);
    bus.mem_ack = 1'b1;
    exp_q.push_back({8'hFE, 32'hAC850010});
    exp_q.push_back({8'hFF, 32'hAC850011});
    send(KIND_SW, 5'd4, 5'd5, 5'd0, 6'd0, 16'h0010);
    send(KIND_SW, 5'd4, 5'd5, 5'd0, 6'd0, 16'h0011);
    send(KIND_SW, 5'd4, 5'd5, 5'd0, 6'd0, 16'h0012);
    repeat (2) tick();
    @(negedge clk);
    check("full_state", 40'(dbg_state), 40'(ST_FULL));
    check("full_err", 40'(bus.full_err), 40'd1);
    check("full_we", 40'(bus.mem_we), 40'd0);
    check("full_in_ready", 40'(bus.in_ready), 40'd0);
    check("full_addr", 40'(bus.mem_addr), 40'hFF);
    check("full_words", 40'(bus.words_written), 40'd2);
    tick();
    exp_q.push_back({8'h10, 32'hAC850012});
    load_base(8'h10);
    repeat (4) tick();
    @(negedge clk);
    check("reload_err", 40'(bus.full_err), 40'd0);
    check("reload_words", 40'(bus.words_written), 40'd1);
    check("reload_addr", 40'(bus.mem_addr), 40'h11);
    check("reload_idle", 40'(dbg_state), 40'(ST_IDLE));
    bus.mem_ack = 1'b0;
    tick();

    // base_load ignored in WRITE; reset abandons a pending write
    load_base(8'h30);
    send(KIND_R, 5'd1, 5'd1, 5'd1, 6'h01, 16'h0);
    send(KIND_R, 5'd1, 5'd1, 5'd1, 6'h02, 16'h0);
    send(KIND_R, 5'd1, 5'd1, 5'd1, 6'h03, 16'h0);
    load_base(8'h77);
    @(negedge clk);
    check("wr_base_ignored", 40'(bus.mem_addr), 40'h30);
    check("wr_before_rst", 40'(bus.mem_we), 40'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_we", 40'(bus.mem_we), 40'd0);
    check("arst_addr", 40'(bus.mem_addr), 40'd0);
    check("arst_wdata", 40'(bus.mem_wdata), 40'd0);
    check("arst_state", 40'(dbg_state), 40'(ST_IDLE));
    repeat (2) tick();
    rst_n = 1'b1;
    bus.mem_ack = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    check("post_rst_we", 40'(bus.mem_we), 40'd0);
    check("post_rst_words", 40'(bus.words_written), 40'd0);
    check("post_rst_ready", 40'(bus.in_ready), 40'd1);
    bus.mem_ack = 1'b0;
    tick();

    check("exp_q_drained", 40'(exp_q.size()), 40'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
